// File: rtl/quad_decoder.sv
// Quadrature/index decoder: synchronizes ChA/ChB/Index, decodes steps into counter enable/direction/load pulses.
// Optional glitch filter on the synchronized inputs is compiled in with `define QUAD_FILTER_EN.
module quad_decoder #(
    parameter int FILTER_LEN = 3,
    parameter int DATA_W     = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              ChA,
    input  logic              ChB,
    input  logic              Index,
    input  logic              IdxEn,
    input  logic [DATA_W-1:0] Preset,
    input  logic              ErrClr,
    output logic              Enable,
    output logic              UpDn,
    output logic              Load,
    output logic [DATA_W-1:0] Data,
    output logic              Err
);

    // state | meaning
    // S00   | last accepted phase A=0 B=0
    // S01   | last accepted phase A=0 B=1
    // S11   | last accepted phase A=1 B=1
    // S10   | last accepted phase A=1 B=0
    typedef enum logic [1:0] {
        S00 = 2'b00,
        S01 = 2'b01,
        S11 = 2'b11,
        S10 = 2'b10
    } phase_t;

    if (FILTER_LEN < 1) begin : g_bad_filter_len
        $error("FILTER_LEN must be at least 1");
    end

    // Bit 2 = A, bit 1 = B, bit 0 = Index.
    logic [2:0] sync1_q, sync2_q;
    logic [2:0] flt;
    logic       vld1_q, vld2_q, init_q;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            vld1_q  <= 1'b0;
            vld2_q  <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            sync1_q <= {ChA, ChB, Index};
            sync2_q <= sync1_q;
            vld1_q  <= 1'b1;
            vld2_q  <= vld1_q;
            init_q  <= vld2_q;
        end
    end

`ifdef QUAD_FILTER_EN
    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(FILTER_LEN - 1);

    logic [2:0]    acc_q;
    logic [CW-1:0] cnt_q [3];

    // Until the first real sample is seen the accepted level follows the synchronizer directly.
    always_comb begin
        flt = acc_q;
        for (int i = 0; i < 3; i++) begin
            if (!init_q || ((sync2_q[i] != acc_q[i]) && (cnt_q[i] == '0)))
                flt[i] = sync2_q[i];
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            acc_q <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= CNT_RELOAD;
        end else begin
            acc_q <= flt;
            for (int i = 0; i < 3; i++) begin
                if (!init_q || (sync2_q[i] == acc_q[i]) || (cnt_q[i] == '0))
                    cnt_q[i] <= CNT_RELOAD;
                else
                    cnt_q[i] <= cnt_q[i] - CW'(1);
            end
        end
    end
`else
    assign flt = sync2_q;
`endif

    phase_t            state_q, state_d;
    logic              step_up, step_dn, illegal, load_ev;
    logic              idx_prev_q;
    logic              enable_q, enable_d, updn_q, updn_d, load_q, load_d, err_q, err_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= S00;
            idx_prev_q <= 1'b0;
        end else if (vld2_q) begin
            state_q    <= state_d;
            idx_prev_q <= flt[0];
        end
    end

    always_comb begin
        state_d  = phase_t'(flt[2:1]);
        step_up  = 1'b0;
        step_dn  = 1'b0;
        illegal  = 1'b0;
        if (init_q && (state_d != state_q)) begin
            case (state_q)
                S00: begin
                    step_up = (state_d == S01);
                    step_dn = (state_d == S10);
                    illegal = (state_d == S11);
                end
                S01: begin
                    step_up = (state_d == S11);
                    step_dn = (state_d == S00);
                    illegal = (state_d == S10);
                end
                S11: begin
                    step_up = (state_d == S10);
                    step_dn = (state_d == S01);
                    illegal = (state_d == S00);
                end
                S10: begin
                    step_up = (state_d == S00);
                    step_dn = (state_d == S11);
                    illegal = (state_d == S01);
                end
                default: ;
            endcase
        end

        load_ev  = init_q && IdxEn && flt[0] && !idx_prev_q;

        // An index load swallows a coincident step, direction untouched.
        enable_d = load_ev || step_up || step_dn;
        load_d   = load_ev;
        updn_d   = updn_q;
        if (!load_ev && step_up) updn_d = 1'b1;
        if (!load_ev && step_dn) updn_d = 1'b0;
        data_d   = load_ev ? Preset : data_q;
        err_d    = illegal || (err_q && !ErrClr);
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            enable_q <= 1'b0;
            updn_q   <= 1'b1;
            load_q   <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            enable_q <= enable_d;
            updn_q   <= updn_d;
            load_q   <= load_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    assign Enable = enable_q;
    assign UpDn   = updn_q;
    assign Load   = load_q;
    assign Data   = data_q;
    assign Err    = err_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Directed table-driven bench for quad_decoder, plus hand sequences for reset and glitch corners.
module tb_quad_decoder;

`ifdef QUAD_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif

    logic       Clock, Reset, ChA, ChB, Index, IdxEn, ErrClr;
    logic [7:0] Preset, Data;
    logic       Enable, UpDn, Load, Err;

    int n_cmp = 0;
    int n_bad = 0;

    quad_decoder #(.FILTER_LEN(3), .DATA_W(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .ChA   (ChA),
        .ChB   (ChB),
        .Index (Index),
        .IdxEn (IdxEn),
        .Preset(Preset),
        .ErrClr(ErrClr),
        .Enable(Enable),
        .UpDn  (UpDn),
        .Load  (Load),
        .Data  (Data),
        .Err   (Err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic       a, b, idx, ien, clr;
        logic [7:0] pre;
        logic       en, ud, ld;
        logic [7:0] dat;
        logic       err;
    } vec_t;

    vec_t tbl [20];

    function automatic vec_t mk(input logic [4:0] in, input logic [7:0] pre,
                                input logic [2:0] out, input logic [7:0] dat, input logic err);
        vec_t v;
        {v.a, v.b, v.idx, v.ien, v.clr} = in;
        v.pre = pre;
        {v.en, v.ud, v.ld} = out;
        v.dat = dat;
        v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " Enable"}, 8'(Enable), 8'h00);
        chk({tag, " UpDn"},   8'(UpDn),   8'h01);
        chk({tag, " Load"},   8'(Load),   8'h00);
        chk({tag, " Data"},   Data,       8'h00);
        chk({tag, " Err"},    8'(Err),    8'h00);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // inputs {a,b,idx,ien,clr}, outputs {en,updn,load}
        tbl[0]  = mk(5'b01000, 8'h00, 3'b110, 8'h00, 1'b0);
        tbl[1]  = mk(5'b11000, 8'h00, 3'b110, 8'h00, 1'b0);
        tbl[2]  = mk(5'b10000, 8'h00, 3'b110, 8'h00, 1'b0);
        tbl[3]  = mk(5'b00000, 8'h00, 3'b110, 8'h00, 1'b0);
        tbl[4]  = mk(5'b10000, 8'h00, 3'b100, 8'h00, 1'b0);
        tbl[5]  = mk(5'b11000, 8'h00, 3'b100, 8'h00, 1'b0);
        tbl[6]  = mk(5'b01000, 8'h00, 3'b100, 8'h00, 1'b0);
        tbl[7]  = mk(5'b00000, 8'h00, 3'b100, 8'h00, 1'b0);
        tbl[8]  = mk(5'b00000, 8'h00, 3'b000, 8'h00, 1'b0);
        tbl[9]  = mk(5'b11000, 8'h00, 3'b000, 8'h00, 1'b1);
        tbl[10] = mk(5'b11001, 8'h00, 3'b000, 8'h00, 1'b0);
        tbl[11] = mk(5'b11110, 8'hA5, 3'b101, 8'hA5, 1'b0);
        tbl[12] = mk(5'b11010, 8'hA5, 3'b000, 8'hA5, 1'b0);
        tbl[13] = mk(5'b11100, 8'hA5, 3'b000, 8'hA5, 1'b0);
        tbl[14] = mk(5'b11110, 8'hA5, 3'b000, 8'hA5, 1'b0);
        tbl[15] = mk(5'b11010, 8'hA5, 3'b000, 8'hA5, 1'b0);
        tbl[16] = mk(5'b10110, 8'h3C, 3'b101, 8'h3C, 1'b0);
        tbl[17] = mk(5'b00100, 8'h3C, 3'b110, 8'h3C, 1'b0);
        tbl[18] = mk(5'b10100, 8'h3C, 3'b100, 8'h3C, 1'b0);
        tbl[19] = mk(5'b01100, 8'h3C, 3'b000, 8'h3C, 1'b1);

        Reset = 1'b1; ChA = 1'b0; ChB = 1'b0; Index = 1'b0;
        IdxEn = 1'b0; ErrClr = 1'b0; Preset = 8'h00;
        repeat (2) @(posedge Clock);
        #1 chk_reset_vals("reset");
        @(negedge Clock) Reset = 1'b0;
        repeat (5) @(posedge Clock);
        #1 chk("post-reset Enable", 8'(Enable), 8'h00);

        for (int i = 0; i < 20; i++) begin
            @(negedge Clock);
            ChA = tbl[i].a; ChB = tbl[i].b; Index = tbl[i].idx;
            IdxEn = tbl[i].ien; ErrClr = tbl[i].clr; Preset = tbl[i].pre;
            for (int c = 1; c <= 8; c++) begin
                @(posedge Clock);
                #1;
                if (c == 1 && tbl[i].clr) chk($sformatf("v%0d Err after ErrClr", i), 8'(Err), 8'h00);
                ErrClr = 1'b0;
                chk($sformatf("v%0d c%0d Enable", i, c), 8'(Enable), 8'((c == LAT) ? tbl[i].en : 1'b0));
                if (c == LAT) begin
                    chk($sformatf("v%0d UpDn", i), 8'(UpDn), 8'(tbl[i].ud));
                    chk($sformatf("v%0d Load", i), 8'(Load), 8'(tbl[i].ld));
                    chk($sformatf("v%0d Data", i), Data,     tbl[i].dat);
                    chk($sformatf("v%0d Err", i),  8'(Err),  8'(tbl[i].err));
                end
            end
        end

        // Reset while a step is in the synchronizers: no pulse may follow release.
        @(negedge Clock);
        ChA = 1'b1; ChB = 1'b1; Index = 1'b0;
        @(posedge Clock);
        @(negedge Clock) Reset = 1'b1;
        #1 chk_reset_vals("mid reset");
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge Clock);
            #1;
            chk($sformatf("rel c%0d Enable", c), 8'(Enable), 8'h00);
            chk($sformatf("rel c%0d Load", c),   8'(Load),   8'h00);
            chk($sformatf("rel c%0d Err", c),    8'(Err),    8'h00);
        end

        // Phase re-initialised to S11; a down step must decode normally.
        @(negedge Clock) ChA = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge Clock);
            #1;
            chk($sformatf("post c%0d Enable", c), 8'(Enable), 8'((c == LAT) ? 1'b1 : 1'b0));
            if (c == LAT) chk("post UpDn", 8'(UpDn), 8'h00);
        end

`ifdef QUAD_FILTER_EN
        // Two-cycle ChA glitch from S01 must be rejected.
        @(negedge Clock) ChA = 1'b1;
        repeat (2) @(negedge Clock);
        ChA = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            @(posedge Clock);
            #1 chk($sformatf("glitch c%0d Enable", c), 8'(Enable), 8'h00);
        end
        chk("glitch Err", 8'(Err), 8'h00);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/quad_decoder.md
QUAD_DECODER -- requirements
Module: quad_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 3, is the number of consecutive identical synchronized samples required before a ChA/ChB/Index level is accepted; it is used only when the filter is compiled in.
REQ-002 Parameter DATA_W, default 8, is the width of Preset and Data.
REQ-003 Clock  input  1  rising-edge system clock.
REQ-004 Reset  input  1  reset, asynchronous, active-high.
REQ-005 ChA  input  1  quadrature channel A, asynchronous to Clock.
REQ-006 ChB  input  1  quadrature channel B, asynchronous to Clock.
REQ-007 Index  input  1  index mark, asynchronous to Clock.
REQ-008 IdxEn  input  1  when high, an index rising edge generates a load.
REQ-009 Preset  input  DATA_W  value presented on Data for an index load.
REQ-010 ErrClr  input  1  synchronous clear of Err.
REQ-011 Enable  output  1  one-cycle pulse, counter enable (step or load).
REQ-012 UpDn  output  1  direction: 1 = up, 0 = down; valid while Enable is high, held otherwise.
REQ-013 Load  output  1  one-cycle pulse, counter load; always coincident with Enable.
REQ-014 Data  output  DATA_W  load value; valid while Load is high.
REQ-015 Err  output  1  sticky illegal-transition flag.

Function
REQ-016 ChA, ChB and Index SHALL each pass through a two-flop synchronizer before any other use.
REQ-017 The decoder SHALL hold the last accepted phase {A,B} as one of four states: S00, S01, S11, S10.
REQ-018 The sequence S00->S01->S11->S10->S00 SHALL be a step up; the reverse sequence SHALL be a step down.
REQ-019 Each valid step SHALL produce exactly one Enable pulse, with UpDn set to the step direction in the same cycle.
REQ-020 A two-bit phase change (S00<->S11, S01<->S10) SHALL set Err, SHALL produce no Enable, and SHALL update the phase state to the new value.
REQ-021 An unchanged phase SHALL produce no output activity.
REQ-022 Latency from a ChA/ChB edge to the Enable pulse SHALL be exactly 3 Clock cycles without the filter: 2 synchronizer cycles plus 1 registered-output cycle.
REQ-023 A synchronized Index rising edge with IdxEn high SHALL assert Load=1 and Enable=1 for one cycle, with Data=Preset sampled in that cycle.
REQ-024 If a valid step and an index load fall in the same cycle, Load SHALL take priority and the step SHALL be discarded; UpDn SHALL keep its previous value.
REQ-025 An index edge with IdxEn low SHALL be ignored; the edge detector SHALL still track the level, so raising IdxEn while Index is high generates no load.
REQ-026 Err SHALL remain high until ErrClr is asserted; if ErrClr and a new illegal transition occur in the same cycle, Err SHALL stay 1.
REQ-027 UpDn SHALL hold its last value between pulses, and Data SHALL hold its last loaded value.

Reset
REQ-028 While Reset is high: Enable=0, UpDn=1, Load=0, Data=0, Err=0; synchronizers, filters and the index edge register are cleared.
REQ-029 The first accepted phase sample after reset deassertion SHALL initialise the phase state without generating a step or an error.
REQ-030 Reset asserted mid-transition SHALL discard any pending step or load; no pulse SHALL appear in the cycle after deassertion.

Configuration
REQ-031 With macro QUAD_FILTER_EN defined, each synchronized input SHALL change its accepted level only after FILTER_LEN consecutive equal samples; shorter glitches SHALL be ignored.
REQ-032 With QUAD_FILTER_EN defined, the edge-to-Enable latency SHALL be 3+FILTER_LEN-1 cycles, which is 5 with the default FILTER_LEN.
REQ-033 Without QUAD_FILTER_EN, no filter logic SHALL exist and FILTER_LEN SHALL be ignored.

Verification
REQ-034 Reset, then drive {A,B} 00,01,11,10,00 with 8 cycles between changes -> 4 Enable pulses with UpDn=1, each 3 cycles after its edge (5 with the filter), Err=0.
REQ-035 Drive {A,B} 00,10,11,01,00 -> 4 Enable pulses with UpDn=0; UpDn stays 0 afterwards.
REQ-036 Jump {A,B} 00->11 -> no Enable, Err=1; pulse ErrClr -> Err=0 on the next cycle.
REQ-037 IdxEn=1, Preset=8'hA5, raise Index -> a single cycle with Load=1, Enable=1, Data=8'hA5; a second Index edge with IdxEn=0 -> no Load.
REQ-038 Coincident index edge and up-step -> Load=1 and Enable=1 only; no separate step pulse; UpDn unchanged.
REQ-039 With QUAD_FILTER_EN defined, a 2-cycle ChA glitch -> no Enable; Reset asserted mid-sequence -> all outputs at reset values and no pulse after release.
